// File: rtl/fixed_pkg.sv
// Shared fixed-point constants and FSM state type for the Q8.8 arithmetic blocks.
package fixed_pkg;

  // Fractional bits of the Q8.8 format.
  localparam int FRAC = 8;

  // Default word width and the matching number of restoring-division steps.
  localparam int BITS = 16;
  localparam int ITER = BITS + FRAC + 1;

  // Clamp values for a 16-bit signed result.
  localparam logic [BITS-1:0] Q_MAX = 16'h7FFF;
  localparam logic [BITS-1:0] Q_MIN = 16'h8000;

  // Divider sequencing: wait for START, iterate, then finish the result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/fsat.sv
// Sign restore and saturation of an unsigned magnitude into a signed word.
// Shared by the divider and by the multiplier datapath when it saturates.
module fsat
  import fixed_pkg::*;
#(
  parameter int bits = BITS,
  parameter int mw   = bits + FRAC + 1
) (
  input  logic [mw-1:0]   mag,
  input  logic            neg,
  input  logic            div0,
  output logic [bits-1:0] q,
  output logic            sat
);

  // Largest representable positive magnitude and the most negative one.
  localparam logic [mw-1:0]   POS_LIM = mw'((64'd1 << (bits - 1)) - 64'd1);
  localparam logic [mw-1:0]   NEG_LIM = mw'(64'd1 << (bits - 1));
  localparam logic [bits-1:0] Q_HI    = {1'b0, {(bits-1){1'b1}}};
  localparam logic [bits-1:0] Q_LO    = {1'b1, {(bits-1){1'b0}}};

  // Choose between the clamped extremes and the sign-restored magnitude.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    q   = mag[bits-1:0];
    sat = 1'b0;
    if (div0) begin
      q   = neg ? Q_LO : Q_HI;
      sat = 1'b1;
    end else if (neg) begin
      if (mag > NEG_LIM) begin
        q   = Q_LO;
        sat = 1'b1;
      end else begin
        // Exactly 2^(bits-1) negates to the most negative code without clamping.
        q = bits'(-mag);
      end
    end else if (mag > POS_LIM) begin
      q   = Q_HI;
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/fdiv.sv
// Signed Q8.8 divider: Q = trunc_toward_zero((A * 2^8) / B).
// Unsigned restoring division on magnitudes, one quotient bit per clock,
// followed by a finishing cycle for sign restore and saturation.
module fdiv
  import fixed_pkg::*;
#(
  parameter int bits = 16
) (
  input  logic            CLK,
  input  logic            RSTN,
  input  logic            START,
  input  logic [bits-1:0] A,
  input  logic [bits-1:0] B,
  output logic            BUSY,
  output logic            DONE,
  output logic [bits-1:0] Q,
  output logic            SAT,
  output logic            DIV0
);

  // Magnitudes need one extra bit so that -2^(bits-1) stays positive.
  localparam int MW  = bits + 1;
  // Dividend is |A| shifted left by the fractional bits.
  localparam int DW  = MW + FRAC;
  // Remainder holds up to 2*divisor - 1.
  localparam int RW  = bits + 2;
  // One step per dividend bit.
  localparam int NIT = bits + FRAC + 1;
  localparam int CW  = $clog2(NIT + 1);

  state_t          state;
  logic [DW-1:0]   dq;      // dividend shifts out at the top, quotient shifts in at the bottom
  logic [MW-1:0]   dvs;     // divisor magnitude
  logic [RW-1:0]   rem;     // partial remainder
  logic            neg;     // sign of the final result
  logic            zero_b;  // divisor was zero
  logic [CW-1:0]   cnt;     // iteration index inside CALC

  logic [MW-1:0]   a_ext;
  logic [MW-1:0]   b_ext;
  logic [MW-1:0]   a_mag;
  logic [MW-1:0]   b_mag;
  logic [RW-1:0]   trial;
  logic [RW-1:0]   dvs_ext;
  logic [RW-1:0]   diff;
  logic            ge;
  logic [bits-1:0] sat_q;
  logic            sat_flag;

  // Operand magnitudes and the trial subtraction for the current step.
  always_comb begin
    a_ext   = {A[bits-1], A};
    b_ext   = {B[bits-1], B};
    a_mag   = A[bits-1] ? -a_ext : a_ext;
    b_mag   = B[bits-1] ? -b_ext : b_ext;
    trial   = {rem[RW-2:0], dq[DW-1]};
    dvs_ext = {1'b0, dvs};
    ge      = (trial >= dvs_ext);
    diff    = trial - dvs_ext;
  end

  fsat #(
    .bits (bits),
    .mw   (DW)
  ) u_fsat (
    .mag  (dq),
    .neg  (neg),
    .div0 (zero_b),
    .q    (sat_q),
    .sat  (sat_flag)
  );

  // Control FSM, datapath shift registers and registered outputs.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state  <= IDLE;
      dq     <= '0;
      dvs    <= '0;
      rem    <= '0;
      neg    <= 1'b0;
      zero_b <= 1'b0;
      cnt    <= '0;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
      Q      <= '0;
      SAT    <= 1'b0;
      DIV0   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            dq     <= {a_mag, {FRAC{1'b0}}};
            dvs    <= b_mag;
            rem    <= '0;
            neg    <= A[bits-1] ^ B[bits-1];
            zero_b <= (B == '0);
            cnt    <= '0;
            BUSY   <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          rem <= ge ? diff : trial;
          dq  <= {dq[DW-2:0], ge};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(NIT - 1)) begin
            state <= FIN;
          end
        end
        FIN: begin
          Q     <= sat_q;
          SAT   <= sat_flag;
          DIV0  <= zero_b;
          DONE  <= 1'b1;
          BUSY  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
